serial_pattern_gen: RTL and testbench
=====================================

// Module: serial_pattern_gen
// PURPOSE
//   Upstream stimulus stage for the lab sequence-detector FSMs: loads a parallel bit
//   pattern and drives it onto the detector's single-bit serial input w, MSB first.
//   Each new bit is marked by a one-cycle Tick, optionally held DIV clocks per bit,
//   and the pattern can repeat continuously. Lets patterns come from switches, not a bench.
// PARAMETERS
//   WIDTH     8   max pattern length in bits (>=2)
//   DIV       1   clocks each bit is held on w (>=1); DIV=1 -> one bit per clock
//   IDLE_BIT  0   value driven on w when not shifting
// PORTS
//   Clock     in   1                  single clock, all state on posedge
//   Reset     in   1                  synchronous, active-high
//   Start     in   1                  request transmission; sampled only in IDLE
//   Stop      in   1                  abort; sampled in SHIFT
//   Repeat    in   1                  captured at Start: 1 -> loop pattern until Stop
//   Pattern   in   WIDTH              bits to send; Pattern[Len-1] goes first
//   Len       in   $clog2(WIDTH+1)    bit count; captured at Start
//   w         out  1                  serial bit stream
//   Tick      out  1                  1 on first cycle of every new bit on w
//   Busy      out  1                  1 while in SHIFT
//   Done      out  1                  one-cycle pulse on completion or abort
//   BitCount  out  $clog2(WIDTH+1)    bits fully sent in current pass
//   CurState  out  2                  IDLE=0, SHIFT=1, DONE=2 (3 unused -> IDLE)
// BEHAVIOUR
//   - Reset: state IDLE, w=IDLE_BIT, Tick=0, Busy=0, Done=0, BitCount=0, CurState=0.
//     Reset overrides all other inputs, including mid-transmission.
//   - All outputs are registered / Moore; nothing depends combinationally on inputs.
//   - IDLE: Start=1 and Stop=0 and Len!=0 at edge k -> SHIFT; shift reg loaded with
//     Pattern<<(WIDTH-Len'), where Len'=min(Len,WIDTH); Len' and Repeat latched.
//     First bit on w in cycle after edge k (latency 1), with Tick=1.
//     Start with Len==0, or Start and Stop together -> stay IDLE, no Done.
//   - SHIFT: w = shreg MSB. Divider counts 0..DIV-1; on wrap, shreg shifts left,
//     BitCount++, and Tick=1 next cycle if more bits remain.
//   - End of pass (BitCount reaches Len'): Repeat=0 -> DONE; Repeat=1 -> reload latched
//     pattern, BitCount=0, next bit is first bit again with no gap cycle.
//   - Stop=1 in SHIFT at edge k -> DONE at k+1; the current bit is truncated.
//     Stop on the same edge as the last bit's end -> DONE (same as normal end).
//   - DONE: lasts 1 cycle; Done=1, Busy=0, w=IDLE_BIT; then IDLE. Start in DONE ignored.
//   - Start in SHIFT is ignored; Pattern/Len/Repeat changes while in SHIFT are ignored.
//   - Tick is 0 in IDLE and DONE. Busy=1 only in SHIFT.
//   - BitCount holds its final value through DONE; clears on next Start.
// TESTING
//   1 DIV=1, Pattern=8'h0B, Len=4, Start pulse at edge 0 -> w=1,0,1,1 cycles 1-4,
//     Tick=1 each cycle, Busy 1-4, Done=1 cycle 5, IDLE cycle 6.
//   2 DIV=3, same stimulus -> each bit held 3 cycles (w 1,1,1,0,0,0,1,1,1,1,1,1),
//     Tick at cycles 1,4,7,10, Done at cycle 13.
//   3 Repeat=1, Pattern=8'h06, Len=3 -> w=1,1,0,1,1,0,... with no gaps; Stop at
//     cycle 5 -> Done=1 cycle 6, w=IDLE_BIT.
//   4 Len=0 or Start+Stop together -> stays IDLE, Busy=0, no Done. Len=15 with
//     WIDTH=8 -> 8 bits sent.
//   5 Reset asserted at cycle 3 of an 8-bit send -> next cycle all outputs at reset
//     values; Start during SHIFT ignored; new Start after reset works normally.
//   6 Drive w into the 7-state detector with Pattern=8'hFF, Len=8, DIV=1 -> detector
//     z asserts from bit 4 on.

Source files
------------

// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if
//   Bundles the control inputs and status outputs of serial_pattern_gen.
//   master: the stimulus side (switch logic or bench) driving Start/Stop/Repeat/Pattern/Len.
//   slave : the generator itself, driving w/Tick/Busy/Done/BitCount/CurState.
//   WIDTH must match the WIDTH of the generator it is connected to.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             Start;
    logic             Stop;
    logic             Repeat;
    logic [WIDTH-1:0] Pattern;
    logic [LW-1:0]    Len;

    logic             w;
    logic             Tick;
    logic             Busy;
    logic             Done;
    logic [LW-1:0]    BitCount;
    logic [1:0]       CurState;

    modport master (
        output Start, Stop, Repeat, Pattern, Len,
        input  w, Tick, Busy, Done, BitCount, CurState
    );

    modport slave (
        input  Start, Stop, Repeat, Pattern, Len,
        output w, Tick, Busy, Done, BitCount, CurState
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
//   Loads a parallel pattern and shifts it out MSB first on the single-bit w, holding
//   each bit DIV clocks. Tick marks the first cycle of each new bit. With Repeat latched
//   at Start the pattern loops back-to-back until Stop.
// Ports
//   Clock   : single clock, all state on posedge
//   Reset   : synchronous, active-high; overrides everything
//   bus     : serial_pattern_gen_if.slave
//             in : Start, Stop, Repeat, Pattern[WIDTH], Len[$clog2(WIDTH+1)]
//             out: w, Tick, Busy, Done, BitCount, CurState (IDLE=0, SHIFT=1, DONE=2)
//   All outputs are registered; none depends combinationally on inputs.
module serial_pattern_gen #(
    parameter int WIDTH    = 8,
    parameter int DIV      = 1,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic               Clock,
    input  logic               Reset,
    serial_pattern_gen_if.slave bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pat_q;    // aligned pattern kept for Repeat reloads
    logic [LW-1:0]    len_q;
    logic             rpt_q;
    logic [DW-1:0]    div_cnt;

    logic [LW-1:0]    len_clip;
    logic [WIDTH-1:0] pat_aligned;
    logic             bit_end;
    logic [LW-1:0]    bc_next;
    logic             last_bit;

    always_comb begin
        len_clip    = (bus.Len > LW'(WIDTH)) ? LW'(WIDTH) : bus.Len;
        // left-justify so the first bit to send sits at the shift register MSB
        pat_aligned = bus.Pattern << (LW'(WIDTH) - len_clip);
        bit_end     = (div_cnt == DW'(DIV - 1));
        bc_next     = bus.BitCount + LW'(1);
        last_bit    = (bc_next == len_q);
    end

    assign bus.CurState = state;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            shreg        <= '0;
            pat_q        <= '0;
            len_q        <= '0;
            rpt_q        <= 1'b0;
            div_cnt      <= '0;
            bus.w        <= IDLE_BIT;
            bus.Tick     <= 1'b0;
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b0;
            bus.BitCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.Tick <= 1'b0;
                    bus.Done <= 1'b0;
                    // Len==0 or a simultaneous Stop is a no-op request
                    if (bus.Start && !bus.Stop && bus.Len != '0) begin
                        state        <= SHIFT;
                        shreg        <= pat_aligned;
                        pat_q        <= pat_aligned;
                        len_q        <= len_clip;
                        rpt_q        <= bus.Repeat;
                        div_cnt      <= '0;
                        bus.BitCount <= '0;
                        bus.w        <= pat_aligned[WIDTH-1];
                        bus.Tick     <= 1'b1;
                        bus.Busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    bus.Tick <= 1'b0;
                    div_cnt  <= bit_end ? '0 : div_cnt + DW'(1);
                    // a bit finishing on the Stop edge still counts as sent
                    if (bit_end)
                        bus.BitCount <= (last_bit && rpt_q && !bus.Stop) ? '0 : bc_next;
                    if (bus.Stop || (bit_end && last_bit && !rpt_q)) begin
                        state    <= DONE;
                        bus.w    <= IDLE_BIT;
                        bus.Busy <= 1'b0;
                        bus.Done <= 1'b1;
                    end else if (bit_end) begin
                        bus.Tick <= 1'b1;
                        if (last_bit) begin
                            // looping: restart the pattern with no gap cycle
                            shreg <= pat_q;
                            bus.w <= pat_q[WIDTH-1];
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            bus.w <= shreg[WIDTH-2];
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.Done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.w    <= IDLE_BIT;
                    bus.Tick <= 1'b0;
                    bus.Busy <= 1'b0;
                    bus.Done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen
//   Directed checks of serial_pattern_gen: dut_a uses DIV=1, dut_b uses DIV=3.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_pattern_gen;
    localparam int WIDTH = 8;

    logic Clock = 1'b0;
    logic Reset;
    int   nchk = 0;
    int   nerr = 0;

    always #5 Clock = ~Clock;

    serial_pattern_gen_if #(.WIDTH(WIDTH)) ifa ();
    serial_pattern_gen_if #(.WIDTH(WIDTH)) ifb ();

    serial_pattern_gen #(.WIDTH(WIDTH), .DIV(1), .IDLE_BIT(1'b0)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(ifa)
    );
    serial_pattern_gen #(.WIDTH(WIDTH), .DIV(3), .IDLE_BIT(1'b0)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_a(input logic [7:0] pat, input logic [3:0] len, input logic rpt);
        ifa.Pattern = pat;
        ifa.Len     = len;
        ifa.Repeat  = rpt;
        ifa.Start   = 1'b1;
        step();
        ifa.Start   = 1'b0;
    endtask

    initial begin
        logic [11:0] wb;
        logic [7:0]  bits;
        int          run;

        Reset = 1'b1;
        ifa.Start = 0; ifa.Stop = 0; ifa.Repeat = 0; ifa.Pattern = '0; ifa.Len = '0;
        ifb.Start = 0; ifb.Stop = 0; ifb.Repeat = 0; ifb.Pattern = '0; ifb.Len = '0;
        step(); step();
        Reset = 1'b0;

        // reset state
        check("rst_w",     {31'd0, ifa.w},    0);
        check("rst_tick",  {31'd0, ifa.Tick}, 0);
        check("rst_busy",  {31'd0, ifa.Busy}, 0);
        check("rst_done",  {31'd0, ifa.Done}, 0);
        check("rst_bc",    {28'd0, ifa.BitCount}, 0);
        check("rst_state", {30'd0, ifa.CurState}, 0);
        check("rst_state_b", {30'd0, ifb.CurState}, 0);

        // 1: DIV=1, 0x0B, Len=4 -> 1,0,1,1
        start_a(8'h0B, 4'd4, 1'b0);
        bits = 8'b0000_1011;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_w%0d", i+1),    {31'd0, ifa.w},    {31'd0, bits[3-i]});
            check($sformatf("t1_tick%0d", i+1), {31'd0, ifa.Tick}, 1);
            check($sformatf("t1_busy%0d", i+1), {31'd0, ifa.Busy}, 1);
            check($sformatf("t1_bc%0d", i+1),   {28'd0, ifa.BitCount}, i);
            step();
        end
        check("t1_done",  {31'd0, ifa.Done}, 1);
        check("t1_busy5", {31'd0, ifa.Busy}, 0);
        check("t1_w5",    {31'd0, ifa.w},    0);
        check("t1_bc5",   {28'd0, ifa.BitCount}, 4);
        check("t1_st5",   {30'd0, ifa.CurState}, 2);
        step();
        check("t1_st6",   {30'd0, ifa.CurState}, 0);
        check("t1_done6", {31'd0, ifa.Done}, 0);
        check("t1_bc6",   {28'd0, ifa.BitCount}, 4);

        // 2: DIV=3, same pattern, each bit held 3 cycles
        ifb.Pattern = 8'h0B; ifb.Len = 4'd4; ifb.Start = 1'b1;
        step();
        ifb.Start = 1'b0;
        wb = 12'b111_000_111_111;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("t2_w%0d", c),    {31'd0, ifb.w},    {31'd0, wb[12-c]});
            check($sformatf("t2_tick%0d", c), {31'd0, ifb.Tick}, ((c - 1) % 3 == 0) ? 1 : 0);
            check($sformatf("t2_done%0d", c), {31'd0, ifb.Done}, 0);
            step();
        end
        check("t2_done13", {31'd0, ifb.Done}, 1);
        check("t2_bc13",   {28'd0, ifb.BitCount}, 4);

        // 3: Repeat, 0x06 Len=3 -> 1,1,0,1,1 ; Stop in cycle 5
        step();
        start_a(8'h06, 4'd3, 1'b1);
        wb = 12'b11011_0000000;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t3_w%0d", c),    {31'd0, ifa.w},    {31'd0, wb[12-c]});
            check($sformatf("t3_tick%0d", c), {31'd0, ifa.Tick}, 1);
            check($sformatf("t3_bc%0d", c),   {28'd0, ifa.BitCount}, (c - 1) % 3);
            if (c == 5) ifa.Stop = 1'b1;
            step();
        end
        ifa.Stop = 1'b0;
        check("t3_done", {31'd0, ifa.Done}, 1);
        check("t3_w6",   {31'd0, ifa.w},    0);
        check("t3_tick6",{31'd0, ifa.Tick}, 0);
        check("t3_bc6",  {28'd0, ifa.BitCount}, 2);
        step();

        // 4: Len=0 and Start+Stop are no-ops; Len=15 clips to 8
        start_a(8'hFF, 4'd0, 1'b0);
        check("t4_len0_st",   {30'd0, ifa.CurState}, 0);
        check("t4_len0_busy", {31'd0, ifa.Busy}, 0);
        step();
        check("t4_len0_done", {31'd0, ifa.Done}, 0);
        ifa.Stop = 1'b1;
        start_a(8'hFF, 4'd4, 1'b0);
        ifa.Stop = 1'b0;
        check("t4_ss_st",   {30'd0, ifa.CurState}, 0);
        check("t4_ss_busy", {31'd0, ifa.Busy}, 0);
        step();
        check("t4_ss_done", {31'd0, ifa.Done}, 0);
        start_a(8'hA5, 4'd15, 1'b0);
        bits = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_w%0d", i+1),    {31'd0, ifa.w},    {31'd0, bits[7-i]});
            check($sformatf("t4_busy%0d", i+1), {31'd0, ifa.Busy}, 1);
            step();
        end
        check("t4_done9", {31'd0, ifa.Done}, 1);
        check("t4_bc9",   {28'd0, ifa.BitCount}, 8);
        step();

        // 5: Start during SHIFT ignored; Reset mid-send; restart
        start_a(8'hF0, 4'd8, 1'b0);
        check("t5_w1", {31'd0, ifa.w}, 1);
        step();
        ifa.Pattern = 8'h00; ifa.Len = 4'd2; ifa.Start = 1'b1;
        step();
        ifa.Start = 1'b0;
        check("t5_st3", {30'd0, ifa.CurState}, 1);
        check("t5_bc3", {28'd0, ifa.BitCount}, 2);
        check("t5_w3",  {31'd0, ifa.w}, 1);
        Reset = 1'b1; ifa.Start = 1'b1;
        step();
        Reset = 1'b0; ifa.Start = 1'b0;
        check("t5_rst_st",   {30'd0, ifa.CurState}, 0);
        check("t5_rst_w",    {31'd0, ifa.w},    0);
        check("t5_rst_tick", {31'd0, ifa.Tick}, 0);
        check("t5_rst_busy", {31'd0, ifa.Busy}, 0);
        check("t5_rst_bc",   {28'd0, ifa.BitCount}, 0);
        start_a(8'h0B, 4'd4, 1'b0);
        check("t5_re_w",    {31'd0, ifa.w},    1);
        check("t5_re_tick", {31'd0, ifa.Tick}, 1);
        check("t5_re_busy", {31'd0, ifa.Busy}, 1);
        for (int i = 0; i < 6; i++) step();

        // 6: run of ones into a 4-in-a-row detector model
        start_a(8'hFF, 4'd8, 1'b0);
        run = 0;
        for (int b = 1; b <= 8; b++) begin
            check($sformatf("t6_w%0d", b), {31'd0, ifa.w}, 1);
            if (ifa.Busy && ifa.Tick) run = ifa.w ? run + 1 : 0;
            check($sformatf("t6_z%0d", b), (run >= 4) ? 1 : 0, (b >= 4) ? 1 : 0);
            step();
        end
        check("t6_done", {31'd0, ifa.Done}, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
